// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Sample point of a bit period; the majority window is centred on it.
    function automatic int uart_mid(input int bit_clk);
        return bit_clk / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for rxd plus a 3-sample majority voter over the
// synchronised stream; everything resets to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic maj
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour, which is what makes this a shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign rxs = sync_q[1];
    // hist_q[0] is rxs one cycle ago, hist_q[1] two cycles ago.
    assign maj = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with one-entry holding register, error flags,
// overrun pulse and RTS. Define UART_RX_PARITY_EN to add the parity bit check.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BIT_CLK    = 87,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 rts
);

    localparam int CNT_W = $clog2(BIT_CLK);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int MID   = uart_mid(BIT_CLK);

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BIT_CLK - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE    = CNT_W'(MID + 1);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

    logic rxs;
    logic maj;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .rxd (rxd),
        .rxs (rxs),
        .maj (maj)
    );

    uart_rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   ferr_q, ferr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   sample;
    logic                   bit_end;
    logic                   commit;

`ifdef UART_RX_PARITY_EN
    logic                   perr_q, perr_d;
    logic                   parity_err_q, parity_err_d;
`else
    logic                   unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    assign sample  = (cnt_q == CNT_SAMPLE);
    assign bit_end = (cnt_q == CNT_LAST);

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        ferr_d      = ferr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = 1'b0;
        commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = parity_err_q;
`endif

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                end
            end
            START: begin
                if (sample && maj) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (sample) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (idx_q == IDX_W'(i)) shift_d[i] = maj;
                    end
                end
                if (bit_end) begin
                    if (idx_q == IDX_LAST_DATA) begin
                        idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) perr_d = (^shift_q) ^ maj ^ (PARITY_ODD == PAR_ODD);
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    ferr_d = ferr_q | ~maj;
                    // Finish at mid stop bit so a back-to-back start edge is seen.
                    if (idx_q == IDX_LAST_STOP) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                if (bit_end && !commit) idx_d = idx_q + IDX_W'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d      = shift_q;
                frame_err_d = ferr_q | ~maj;
                valid_d     = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = perr_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            ferr_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            ferr_q      <= ferr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rts       = ~valid_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus random
// frames scored against a frame-level model (honours UART_RX_PARITY_EN).
module tb_uart_rx_frame;

    localparam int BC   = 16;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
    localparam int MID  = BC / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Cycles from the start-bit drive to the edge where rx_valid rises.
    localparam int LAT = 4 + (DB + P + SB) * BC + MID + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          rts;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .BIT_CLK    (BC),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB),
        .PARITY_ODD (PODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .rts        (rts)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int     rise_q[$];
    int     n_ovr = 0;
    int     ovr_cyc = -1;
    int     rts_bad = 0;
    int     n_got = 0;
    logic   prev_valid = 1'b0;
    logic   rand_ready = 1'b0;
    logic   ready_fix = 1'b0;

    always @(posedge clk) begin
        #1;
        rx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fix;
    end

    // Monitor: records valid rises and overrun pulses, scores consumed frames.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (rts !== ~rx_valid) rts_bad++;
            if (rx_valid && !prev_valid) rise_q.push_back(cyc);
            prev_valid = rx_valid;
            if (overrun) begin
                n_ovr++;
                ovr_cyc = cyc;
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    mon_f = exp_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, mon_f.data});
                    check("frame_err", {31'd0, frame_err}, {31'd0, mon_f.ferr});
                    check("parity_err", {31'd0, parity_err}, {31'd0, mon_f.perr});
                    n_got++;
                end
            end
        end
    end

    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    function automatic logic model_perr(input logic [DB-1:0] d, input logic pbit);
        return (P == 1) ? ((^d) ^ pbit ^ (PODD != 0)) : 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; n0 is the cycle count when the start bit went low.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v,
                              output int n0);
        n0  = cyc;
        rxd = 1'b0;
        tick(BC);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            tick(BC);
        end
        if (P == 1) begin
            rxd = par_v;
            tick(BC);
        end
        for (int i = 0; i < SB; i++) begin
            rxd = stop_v;
            tick(BC);
        end
        rxd = 1'b1;
    endtask

    task automatic send_exp(input logic [DB-1:0] d, input logic stop_v, input logic par_v,
                            output int n0);
        frame_t f;
        f.data = d;
        f.ferr = ~stop_v;
        f.perr = model_perr(d, par_v);
        exp_q.push_back(f);
        send_frame(d, stop_v, par_v, n0);
    endtask

    task automatic wait_drain(input string tag);
        int b = 0;
        while (exp_q.size() != 0 && b < 40 * BC) begin
            tick(1);
            b++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
        check({tag, "_rts"}, {31'd0, rts}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0, n1, n2, r0, o0, g0, gap;
        logic [DB-1:0] d;
        logic sv, pv;

        // Reset state
        rst = 1'b1;
        tick(4);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_fix = 1'b1;
        tick(BC);

        // Back-to-back frames with latency check
        send_exp(8'h55, 1'b1, good_par(8'h55), n0);
        send_exp(8'hA3, 1'b1, good_par(8'hA3), n1);
        tick(2 * BC);
        wait_drain("b2b_drain");
        check("b2b_rises", rise_q.size(), 2);
        check("commit_cycle", (rise_q.size() > 0) ? rise_q[0] : -1, n0 + LAT);

        // Short start glitch is rejected
        r0 = rise_q.size();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(3 * BC);
        check("glitch_no_valid", rise_q.size() - r0, 0);

        // Framing error then clean frame
        send_exp(8'h3C, 1'b0, good_par(8'h3C), n0);
        tick(2 * BC);
        send_exp(8'h11, 1'b1, good_par(8'h11), n0);
        tick(2 * BC);
        wait_drain("ferr_drain");

`ifdef UART_RX_PARITY_EN
        send_exp(8'h07, 1'b1, 1'b0, n0);
        send_exp(8'h07, 1'b1, 1'b1, n0);
        tick(2 * BC);
        wait_drain("parity_drain");
`endif

        // Overrun with consumer stalled
        ready_fix = 1'b0;
        tick(2);
        o0 = n_ovr;
        send_frame(8'h01, 1'b1, good_par(8'h01), n1);
        send_frame(8'h02, 1'b1, good_par(8'h02), n2);
        tick(2 * BC);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_cycle", ovr_cyc, n2 + LAT);
        check("hold_data", {24'd0, rx_data}, 32'h01);
        check("hold_valid", {31'd0, rx_valid}, 32'd1);
        check("hold_rts", {31'd0, rts}, 32'd0);
        check("hold_ferr", {31'd0, frame_err}, 32'd0);

        // Reset in the middle of DATA, then a full frame
        rxd = 1'b0;
        tick(BC);
        d = 8'h9A;
        for (int i = 0; i < 3; i++) begin
            rxd = d[i];
            tick(BC);
        end
        tick(MID);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        tick(3);
        rst = 1'b0;
        exp_q.delete();
        tick(2 * BC);
        ready_fix = 1'b1;
        g0 = n_got;
        send_exp(8'h9A, 1'b1, good_par(8'h9A), n0);
        tick(2 * BC);
        wait_drain("post_rst_drain");
        check("post_rst_frames", n_got - g0, 1);

        // Random frames with random consumer backpressure
        rand_ready = 1'b1;
        o0 = n_ovr;
        for (int k = 0; k < 24; k++) begin
            d  = DB'($urandom);
            sv = ($urandom_range(0, 5) != 0);
            pv = (P == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            send_exp(d, sv, pv, n0);
            gap = sv ? $urandom_range(0, BC) : 2 * BC;
            tick(gap);
        end
        tick(2 * BC);
        wait_drain("random_drain");
        rand_ready = 1'b0;
        check("random_no_overrun", n_ovr - o0, 0);

        check("rts_tracks_valid", rts_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
